// File: rtl/bg_subtract_pkg.sv
// rtl/bg_subtract_pkg.sv - shared state encoding, mask codes and default geometry for the motion-detect pipeline
package bg_subtract_pkg;

  typedef enum logic [1:0] {
    READ  = 2'd0,
    WRITE = 2'd1
  } state_t;

  // The highlight stage treats MASK_MOTION as its highlight code.
  localparam logic [7:0] MASK_MOTION = 8'h00;
  localparam logic [7:0] MASK_STATIC = 8'hff;

  localparam int unsigned DEF_THRESHOLD = 50;
  localparam int unsigned DEF_WIDTH     = 720;
  localparam int unsigned DEF_HEIGHT    = 540;

endpackage

// File: rtl/bg_subtract.sv
// rtl/bg_subtract.sv - background subtraction: |img - base| > THRESHOLD gives a motion mask pixel
// Optional per-frame motion pixel count enabled by MOTION_COUNT_EN.
module bg_subtract
  import bg_subtract_pkg::*;
#(
  parameter int unsigned THRESHOLD = DEF_THRESHOLD,
  parameter int unsigned WIDTH     = DEF_WIDTH,
  parameter int unsigned HEIGHT    = DEF_HEIGHT
) (
  input  logic       clock,
  input  logic       reset,
  output logic       base_rd_en,
  input  logic       base_empty,
  input  logic [7:0] base_dout,
  output logic       img_rd_en,
  input  logic       img_empty,
  input  logic [7:0] img_dout,
  output logic       mask_wr_en,
  input  logic       mask_full,
  output logic [7:0] mask_din,
  output logic       frame_done
`ifdef MOTION_COUNT_EN
  ,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] motion_count
`endif
);

  localparam int unsigned NPIX = WIDTH * HEIGHT;
  localparam int unsigned CW   = $clog2(NPIX + 1);
  localparam logic [7:0]  THR  = 8'(THRESHOLD);

  state_t            state, state_next;
  logic [7:0]        diff;
  logic [CW-1:0]     pix_cnt;
  logic signed [8:0] sub_diff;
  logic [7:0]        abs_diff;
  logic              load_diff;
  logic              is_motion;
  logic              last_pix;

  // 9-bit signed difference; its magnitude always fits in 8 bits.
  assign sub_diff  = $signed({1'b0, img_dout}) - $signed({1'b0, base_dout});
  assign abs_diff  = sub_diff[8] ? 8'(-sub_diff) : sub_diff[7:0];
  assign is_motion = (diff > THR);
  assign last_pix  = (pix_cnt == CW'(NPIX - 1));

  always_comb begin
    state_next = state;
    base_rd_en = 1'b0;
    img_rd_en  = 1'b0;
    mask_wr_en = 1'b0;
    mask_din   = 8'h00;
    load_diff  = 1'b0;
    case (state)
      READ: begin
        // Both streams advance together so background and image stay pixel-aligned.
        if (!base_empty && !img_empty) begin
          base_rd_en = 1'b1;
          img_rd_en  = 1'b1;
          load_diff  = 1'b1;
          state_next = WRITE;
        end
      end
      WRITE: begin
        if (!mask_full) begin
          mask_wr_en = 1'b1;
          mask_din   = is_motion ? MASK_MOTION : MASK_STATIC;
          state_next = READ;
        end
      end
      default: state_next = READ;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= READ;
      diff       <= 8'h00;
      pix_cnt    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_next;
      frame_done <= mask_wr_en && last_pix;
      if (load_diff) begin
        diff <= abs_diff;
      end
      if (mask_wr_en) begin
        pix_cnt <= last_pix ? '0 : pix_cnt + CW'(1);
      end
    end
  end

`ifdef MOTION_COUNT_EN
  logic [CW-1:0] motion_acc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      motion_acc   <= '0;
      motion_count <= '0;
    end else if (mask_wr_en) begin
      if (last_pix) begin
        motion_count <= motion_acc + CW'(is_motion);
        motion_acc   <= '0;
      end else begin
        motion_acc <= motion_acc + CW'(is_motion);
      end
    end
  end
`endif

endmodule

// File: doc/bg_subtract.md
# bg_subtract

Background-subtraction stage of the motion-detect pipeline. Consumes two 8-bit grayscale pixel streams from FIFOs: the stored background frame and the current frame. For each pixel it computes the absolute difference, compares it with a threshold, and writes an 8-bit motion mask into the mask FIFO. The highlight stage reads that FIFO directly downstream.

## Interface

Parameters:
- THRESHOLD, 50: motion threshold; a pixel is motion when |diff| > THRESHOLD (8-bit unsigned).
- WIDTH, 720: frame width in pixels.
- HEIGHT, 540: frame height in pixels.

Ports:
- clock  in  1  system clock
- reset  in  1  reset; asynchronous, active-high
- base_rd_en  out  1  pop the background FIFO
- base_empty  in  1  background FIFO empty
- base_dout  in  8  background gray pixel (FWFT data)
- img_rd_en  out  1  pop the current-frame FIFO
- img_empty  in  1  current-frame FIFO empty
- img_dout  in  8  current gray pixel (FWFT data)
- mask_wr_en  out  1  push to the mask FIFO
- mask_full  in  1  mask FIFO full
- mask_din  out  8  mask pixel
- frame_done  out  1  one-cycle pulse after the last pixel of a frame is written
- motion_count  out  $clog2(WIDTH*HEIGHT+1)  motion pixels in the last completed frame (present only with MOTION_COUNT_EN)

## Operation

- Mask encoding: motion pixel = 8'h00; static pixel = 8'hff. Downstream treats 8'h00 as the highlight code.
- Input FIFOs are first-word-fall-through: the dout value is valid while empty is 0 and is consumed by rd_en.
- FSM states:
  - READ:
    - When base_empty == 0 and img_empty == 0, assert base_rd_en and img_rd_en in the same cycle.
    - Register diff = |img_dout − base_dout|, computed as a 9-bit signed subtraction with the absolute value truncated to 8 bits (range 0..255).
    - Go to WRITE.
    - If either FIFO is empty, pop neither and stay in READ. Never pop only one FIFO.
  - WRITE:
    - When mask_full == 0, assert mask_wr_en and drive mask_din = (diff > THRESHOLD) ? 8'h00 : 8'hff.
    - Advance the pixel counter and go to READ.
    - If mask_full == 1, hold diff and stay in WRITE.
  - Illegal state: go to READ with all strobes deasserted.
- Pixel counter: 0..WIDTH*HEIGHT−1.
  - Increments on each mask write.
  - On the write of pixel WIDTH*HEIGHT−1 it wraps to 0 and sets frame_done for the following cycle.
- mask_din is 8'h00 whenever mask_wr_en is 0. Verification checks mask_din only on write cycles.

## Timing

- Reset values:
  - state = READ; diff = 0; pixel counter = 0.
  - All rd_en and wr_en = 0; mask_din = 0; frame_done = 0; motion_count = 0.
- Strobes (rd_en, wr_en) are combinational from state and the FIFO flags. frame_done is registered.
- Latency: a pop in cycle N gives the mask write in cycle N+1 at the earliest.
- Throughput: at most 1 pixel per 2 cycles.
- Backpressure: a pixel held in WRITE is never lost or duplicated. No read occurs while in WRITE.
- frame_done is high exactly in the cycle after the final write of a frame. It never overlaps the next frame's first write, because the first write cannot come earlier than 2 cycles later.
- Reset mid-frame: the counter, diff and the motion accumulator are discarded. The next popped pixel is treated as pixel 0.

## Configuration

- MOTION_COUNT_EN defined:
  - An internal accumulator counts mask writes with value 8'h00.
  - On the last pixel's write, motion_count loads accumulator + (current pixel is motion), and the accumulator clears to 0 in the same cycle.
  - motion_count holds until the next frame end.
- MOTION_COUNT_EN undefined: the accumulator and the motion_count port are absent. All other behaviour is identical.

## Structure

- Package bg_subtract_pkg holds:
  - the state enum (READ, WRITE);
  - MASK_MOTION = 8'h00 and MASK_STATIC = 8'hff;
  - the default THRESHOLD, WIDTH and HEIGHT.
- The package is shared with the highlight stage so both sides use the same mask constants.
- Single module, no sub-module: the abs-diff is one inline expression.

## Test plan

- Base 100, img 200 (|diff| 100 > 50) -> one write of mask 8'h00. Base 100, img 150 (diff 50) -> 8'hff (strict compare).
- Underflow: base 200, img 10 -> diff 190 -> 8'h00. Base 0, img 255 -> diff 255 -> 8'h00.
- Only img non-empty for 10 cycles -> no rd_en on either FIFO. When base becomes non-empty -> both pop in the same cycle.
- Hold mask_full high for 5 cycles while in WRITE -> mask_wr_en stays low and exactly one write occurs after release with the held value. No pops occur meanwhile.
- WIDTH=4, HEIGHT=2, pixels 3 of which are motion -> frame_done pulses once, one cycle after the 8th write. With MOTION_COUNT_EN, motion_count = 3. Second frame with 0 motion pixels -> motion_count = 0.
- Assert reset after 3 pixels of a frame -> all outputs return to 0. The next frame's frame_done follows exactly WIDTH*HEIGHT further writes.
